// File: rtl/mux_share_arbiter.sv
// rtl/mux_share_arbiter.sv - two-requester arbiter sharing one external 2:1 mux, with result capture and grant counters
module mux_share_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic             data_a,
   input  logic             req_b,
   input  logic             data_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             mux_a,
   output logic             mux_b,
   output logic             sel,
   input  logic             mux_z,
   output logic             out_valid,
   output logic             out_data,
   output logic             out_src,
   input  logic             out_ready,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   typedef enum logic [1:0] {IDLE, SERVE, HOLD} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state;
   logic   pri;
   logic   owner;
   logic   any_req;
   logic   win;

   assign mux_a   = data_a;
   assign mux_b   = data_b;
   assign sel     = owner;
   assign any_req = req_a | req_b;
   // A lone requester always wins; the pointer only breaks ties.
   assign win     = (req_a & req_b) ? pri : req_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pri       <= 1'b0;
         owner     <= 1'b0;
         gnt_a     <= 1'b0;
         gnt_b     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 1'b0;
         out_src   <= 1'b0;
         cnt_a     <= '0;
         cnt_b     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state <= SERVE;
                  owner <= win;
                  pri   <= ~win;
                  gnt_a <= ~win;
                  gnt_b <= win;
               end
            end
            SERVE: begin
               gnt_a     <= 1'b0;
               gnt_b     <= 1'b0;
               out_data  <= mux_z;
               out_src   <= owner;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (any_req) begin
                     state <= SERVE;
                     owner <= win;
                     pri   <= ~win;
                     gnt_a <= ~win;
                     gnt_b <= win;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // Clear takes precedence over a coincident increment.
         if (clr_cnt) begin
            cnt_a <= '0;
            cnt_b <= '0;
         end else if (state == SERVE) begin
            if (!owner && cnt_a != CNT_MAX) cnt_a <= cnt_a + CNT_W'(1);
            if (owner && cnt_b != CNT_MAX)  cnt_b <= cnt_b + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb/tb_mux_share_arbiter.sv - directed bench for mux_share_arbiter with an external shared mux model
module tb_mux_share_arbiter;

   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_a = 1'b0, data_a = 1'b0, req_b = 1'b0, data_b = 1'b0;
   logic             gnt_a, gnt_b, mux_a, mux_b, sel, mux_z;
   logic             out_valid, out_data, out_src;
   logic             out_ready = 1'b0, clr_cnt = 1'b0;
   logic [CNT_W-1:0] cnt_a, cnt_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic src;
      logic da;
      logic db;
      logic exp_data;
   } vec_t;

   vec_t vecs[8];

   assign mux_z = (mux_a & ~sel) | (sel & mux_b);

   always #5 clk = ~clk;

   mux_share_arbiter #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .mux_a(mux_a), .mux_b(mux_b),
      .sel(sel), .mux_z(mux_z),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
      .out_ready(out_ready), .clr_cnt(clr_cnt),
      .cnt_a(cnt_a), .cnt_b(cnt_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_a = 0; req_b = 0; out_ready = 0; clr_cnt = 0;
      rst_n = 0;
      step();
      rst_n = 1;
   endtask

   initial begin
      vecs[0] = '{src: 1'b0, da: 1'b0, db: 1'b0, exp_data: 1'b0};
      vecs[1] = '{src: 1'b0, da: 1'b0, db: 1'b1, exp_data: 1'b0};
      vecs[2] = '{src: 1'b0, da: 1'b1, db: 1'b0, exp_data: 1'b1};
      vecs[3] = '{src: 1'b0, da: 1'b1, db: 1'b1, exp_data: 1'b1};
      vecs[4] = '{src: 1'b1, da: 1'b0, db: 1'b0, exp_data: 1'b0};
      vecs[5] = '{src: 1'b1, da: 1'b0, db: 1'b1, exp_data: 1'b1};
      vecs[6] = '{src: 1'b1, da: 1'b1, db: 1'b0, exp_data: 1'b0};
      vecs[7] = '{src: 1'b1, da: 1'b1, db: 1'b1, exp_data: 1'b1};

      // reset state
      #2;
      chk("rst_gnt", {gnt_a, gnt_b}, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_sel", sel, 0);
      chk("rst_cnt", {cnt_a, cnt_b}, 0);
      step();
      rst_n = 1;

      // single A transfer after reset
      req_a = 1; data_a = 1;
      step();
      chk("a1_gnt", {gnt_a, gnt_b}, 2'b10);
      chk("a1_sel", sel, 0);
      req_a = 0;
      step();
      chk("a1_gnt_off", {gnt_a, gnt_b}, 0);
      chk("a1_out", {out_valid, out_data, out_src}, 3'b110);
      chk("a1_cnt", cnt_a, 1);
      out_ready = 1;
      step();
      chk("a1_release", out_valid, 0);
      out_ready = 0;

      // backpressure: B granted, held for 5 cycles while both request
      req_b = 1; data_b = 0; data_a = 1;
      step();
      chk("bp_gnt", {gnt_a, gnt_b}, 2'b01);
      chk("bp_sel", sel, 1);
      req_a = 1;
      step();
      chk("bp_out", {out_valid, out_data, out_src}, 3'b101);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp_hold%0d_out", i), {out_valid, out_data, out_src}, 3'b101);
         chk($sformatf("bp_hold%0d_gnt", i), {gnt_a, gnt_b}, 0);
         chk($sformatf("bp_hold%0d_sel", i), sel, 1);
      end
      req_b = 0; out_ready = 1;
      step();
      chk("bp_next_gnt", {gnt_a, gnt_b}, 2'b10);
      chk("bp_next_valid", out_valid, 0);
      chk("bp_next_sel", sel, 0);
      req_a = 0;
      step();
      chk("bp_next_out", {out_valid, out_data, out_src}, 3'b110);
      step();
      chk("bp_idle", out_valid, 0);
      out_ready = 0;

      // data sweep through the shared mux
      for (int v = 0; v < 8; v++) begin
         req_a = ~vecs[v].src; req_b = vecs[v].src;
         data_a = vecs[v].da; data_b = vecs[v].db;
         step();
         chk($sformatf("sw%0d_gnt", v), {gnt_a, gnt_b}, {~vecs[v].src, vecs[v].src});
         chk($sformatf("sw%0d_sel", v), sel, vecs[v].src);
         req_a = 0; req_b = 0;
         step();
         chk($sformatf("sw%0d_out", v), {out_valid, out_data, out_src},
             {1'b1, vecs[v].exp_data, vecs[v].src});
         out_ready = 1;
         step();
         chk($sformatf("sw%0d_rel", v), out_valid, 0);
         out_ready = 0;
      end

      // saturation at 3 with CNT_W=2, then clear coincident with a grant
      clr_cnt = 1;
      step();
      clr_cnt = 0;
      chk("sat_clr0", {cnt_a, cnt_b}, 0);
      for (int g = 1; g <= 5; g++) begin
         req_a = 1; out_ready = 1;
         step();
         req_a = 0;
         step();
         chk($sformatf("sat_cnt%0d", g), cnt_a, (g > 3) ? 3 : g);
         step();
      end
      req_a = 1;
      step();
      chk("sat_g6_gnt", gnt_a, 1);
      req_a = 0; clr_cnt = 1;
      step();
      clr_cnt = 0;
      chk("sat_g6_cnt", cnt_a, 0);
      chk("sat_g6_valid", out_valid, 1);
      step();
      out_ready = 0;

      // both requesting continuously: strict alternation starting with A
      do_reset();
      req_a = 1; req_b = 1; data_a = 1; data_b = 0; out_ready = 1;
      for (int k = 0; k < 4; k++) begin
         logic exp_src;
         exp_src = k[0];
         step();
         chk($sformatf("alt%0d_gnt", k), {gnt_a, gnt_b}, {~exp_src, exp_src});
         if (k == 3) begin
            req_a = 0; req_b = 0;
         end
         step();
         chk($sformatf("alt%0d_out", k), {out_valid, out_data, out_src}, {1'b1, ~exp_src, exp_src});
      end
      step();
      chk("alt_idle", {out_valid, gnt_a, gnt_b}, 0);
      chk("alt_cnt", {cnt_a, cnt_b}, 4'b1010);
      out_ready = 0;

      // async reset during HOLD, then first tie goes to A
      req_b = 1;
      step();
      req_b = 0;
      step();
      chk("ar_pre_valid", out_valid, 1);
      #3 rst_n = 0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_cnt", {cnt_a, cnt_b}, 0);
      chk("ar_sel", sel, 0);
      step();
      rst_n = 1;
      step();
      chk("ar_quiet", {gnt_a, gnt_b, out_valid}, 0);
      req_a = 1; req_b = 1;
      step();
      chk("ar_first_tie", {gnt_a, gnt_b}, 2'b10);
      req_a = 0; req_b = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
